// File: rtl/tdm_pkg.sv
// Shared TDM constants and types for the 1x16 demux and its transmitter.
package tdm_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] ch_vec_t;

  function automatic sel_t sel_next(sel_t s);
    return sel_t'(s + sel_t'(1));
  endfunction

endpackage

// File: rtl/demux1x16_dec.sv
// One-hot shadow write-enable decode for the 1x16 TDM demux.
module demux1x16_dec
  import tdm_pkg::*;
(
  input  sel_t    sel_i,
  input  logic    valid_i,
  output ch_vec_t we_o
);

  always_comb begin
    we_o = '0;
    if (valid_i) we_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux1x16.sv
// Serial TDM to 16-bit frame demux; sync_err output exists only when
// TDM_SYNC_ERR_EN is defined.
module tdm_demux1x16
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  input  logic              in_valid,
  input  logic              sync,
  output logic [NUM_CH-1:0] out,
  output logic [SEL_W-1:0]  sel,
  output logic              frame_valid
`ifdef TDM_SYNC_ERR_EN
  ,
  output logic              sync_err
`endif
);

  sel_t    sel_q, sel_d, sel_eff;
  ch_vec_t shadow_q, shadow_d;
  ch_vec_t out_q, out_d;
  ch_vec_t we;
  logic    fv_q, fv_d;
  logic    last;

  assign sel_eff = sync ? '0 : sel_q;
  assign last    = in_valid && (sel_eff == sel_t'(NUM_CH - 1));

  demux1x16_dec u_dec (
    .sel_i   (sel_eff),
    .valid_i (in_valid),
    .we_o    (we)
  );

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (we[i]) shadow_d[i] = in;
    end
    sel_d = in_valid ? sel_next(sel_eff) : sel_q;
    // shadow_d already holds the final bit in slot 15
    out_d = last ? shadow_d : out_q;
    fv_d  = last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      fv_q     <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      fv_q     <= fv_d;
    end
  end

  assign out         = out_q;
  assign sel         = sel_q;
  assign frame_valid = fv_q;

`ifdef TDM_SYNC_ERR_EN
  logic err_q, err_d;

  assign err_d = in_valid && sync && (sel_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign sync_err = err_q;
`endif

endmodule

// File: doc/tdm_demux1x16.md
TDM_DEMUX1X16 -- requirements
Module: tdm_demux1x16

Interface
REQ-001 The block SHALL have no parameters; channel count is fixed at 16 and slot index width at 4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in  input  1  serial TDM data bit for the current slot.
REQ-005 in_valid  input  1  qualifies in; when 0, the cycle is ignored.
REQ-006 sync  input  1  frame-start marker; meaningful only when in_valid=1.
REQ-007 out  output  16  registered frame; out[i] holds slot i of the last complete frame.
REQ-008 sel  output  4  registered slot index expected for the next valid bit.
REQ-009 frame_valid  output  1  one-cycle pulse; out was updated on the previous edge.
REQ-010 sync_err  output  1  present only with TDM_SYNC_ERR_EN; one-cycle pulse on a mid-frame sync.

Function
REQ-011 The effective slot SHALL be sel_eff = (sync ? 0 : sel), computed when in_valid=1.
REQ-012 On in_valid=1, in SHALL be written to shadow[sel_eff], and sel SHALL become sel_eff+1 modulo 16 (15 wraps to 0).
REQ-013 On in_valid=0, sel, shadow, out and sync SHALL have no effect on state; frame_valid and sync_err SHALL be 0 the next cycle.
REQ-014 On in_valid=1 with sel_eff=15, out SHALL load {in, shadow[14:0]} at that edge, and frame_valid SHALL be 1 for exactly the following cycle.
REQ-015 Latency SHALL be: last slot bit sampled at edge N; out and frame_valid visible after edge N, with no further delay.
REQ-016 Slot i of a frame SHALL map to out[i], matching mux16x1 bit order (sel=i selects in[i]).
REQ-017 A sync with in_valid=1 and sel!=0 SHALL abandon the partial frame: out is not updated, no frame_valid is produced for the abandoned frame, and the bit is stored as slot 0.
REQ-018 A sync with sel=0 SHALL be a normal frame start with no error.
REQ-019 Frames without sync SHALL continue back-to-back through the 15->0 wrap.
REQ-020 The shadow register is not cleared on sync; each completed frame SHALL overwrite all 16 slots.

Reset
REQ-021 While rst_n=0, the block SHALL hold sel=0, shadow=0, out=16'h0000, frame_valid=0 and sync_err=0 asynchronously.
REQ-022 A reset mid-frame SHALL discard the partial frame; the first valid bit after release SHALL be slot 0.

Configuration
REQ-023 With macro TDM_SYNC_ERR_EN defined, the sync_err port and register SHALL exist and pulse for one cycle after each REQ-017 event.
REQ-024 Without TDM_SYNC_ERR_EN, the sync_err port SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 The shared package tdm_pkg SHALL hold NUM_CH=16 and SEL_W=4 for use by this block and its transmitter counterpart.
REQ-026 One combinational sub-module, demux1x16_dec, SHALL decode sel_eff and in_valid into a 16-bit one-hot shadow write enable.

Verification
REQ-027 Reset: rst_n=0 during traffic -> out=0000, sel=0, frame_valid=0 immediately, without waiting for a clock edge.
REQ-028 Frame capture: sync on the first bit, then 16 consecutive valid bits of 16'hA5C3 sent LSB first -> out=16'hA5C3, with a single frame_valid pulse in the cycle after the 16th bit.
REQ-029 Gaps: same frame with in_valid=0 bubbles after slots 3 and 11 -> sel stalls during the bubbles; out=16'hA5C3 and one frame_valid pulse.
REQ-030 Mid-frame sync: sync asserted at sel=7 -> out keeps its old value, sel=1 next, sync_err pulses (macro on); the following frame 16'h1234 is captured correctly.
REQ-031 Back-to-back: two frames, 16'hFFFF then 16'h0001, with no sync between them -> sel wraps 15->0, frame_valid pulses 16 valid cycles apart, and out values are correct.
REQ-032 Reset mid-frame: rst_n pulsed at sel=9 -> all outputs are 0; the next 16 valid bits form a complete frame starting at slot 0.
